lfsr_stream: RTL and testbench
==============================

LFSR_STREAM -- requirements
Module: lfsr_stream

Interface
REQ-001 SHALL have parameter N, default 16, LFSR and data width (4..32).
REQ-002 SHALL have parameter CH, default 4, number of independent LFSR channels (1..16).
REQ-003 SHALL have parameter DEPTH, default 8, output FIFO entries (power of two, >=2).
REQ-004 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port W  input  1  register write strobe.
REQ-007 SHALL have port A  input  16  register address.
REQ-008 SHALL have port D  input  N  write data.
REQ-009 SHALL have port out_valid  output  1  FIFO head holds a word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head this cycle.
REQ-011 SHALL have port out_data  output  N  generated word.
REQ-012 SHALL have port out_ch  output  max(1,$clog2(CH))  source channel of out_data.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 SHALL have port busy  output  1  FSM not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of STEP or COUNT run.

Function
REQ-016 SHALL decode writes (W=1): 0x0010 CTRL (D[1:0] mode, D[2] flush); 0x0011 COUNT; 0x0012 ENMASK (D[CH-1:0]); 0x0020+c POLY[c]; 0x0030+c SEED[c] (loads state[c]); other addresses ignored.
REQ-017 SHALL step a channel Galois-style: state[0]=1 -> (state>>1) XOR POLY[c]; else state>>1.
REQ-018 SHALL run FSM IDLE/RUN/STEP/COUNT: CTRL mode 00->IDLE, 10->RUN, 01->STEP, 11->COUNT; taken the cycle after the CTRL write.
REQ-019 SHALL generate at most one word per cycle, only when FSM not IDLE, ENMASK nonzero, and FIFO not full or popped the same cycle.
REQ-020 SHALL choose the generating channel round-robin over enabled channels, starting after the last served channel; channel 0 first after reset.
REQ-021 SHALL push the post-step state with its channel index; out_data valid the cycle after generation (one-cycle latency).
REQ-022 SHALL leave STEP after exactly one generated word: FSM->IDLE, CTRL mode->00, done=1 one cycle.
REQ-023 SHALL in COUNT generate exactly COUNT words (COUNT=0 -> immediate done, no words), then IDLE, mode 00, done=1.
REQ-024 SHALL stall (no step, no count decrement) while the FIFO is full and not popped; no word is dropped or duplicated.
REQ-025 SHALL give SEED/POLY writes priority over a same-cycle step of that channel; that channel does not generate that cycle.
REQ-026 SHALL on CTRL write of mode 00 stop generation from the next cycle, keep FIFO contents, no done pulse.
REQ-027 SHALL on flush (D[2]=1) empty the FIFO in one cycle (level=0 next cycle); flush is self-clearing; same-cycle generation is discarded.
REQ-028 SHALL leave an all-zero channel at zero (no lockup recovery).
REQ-029 SHALL pop the FIFO head when out_valid and out_ready; out_data/out_ch stable while out_valid and not out_ready.

Reset
REQ-030 SHALL on reset assert: FSM IDLE, CTRL 0, COUNT 0, ENMASK 0, all POLY and state 0, FIFO empty, round-robin pointer to channel 0.
REQ-031 SHALL hold outputs during reset: out_valid 0, level 0, busy 0, done 0, out_data 0, out_ch 0.
REQ-032 SHALL abandon any run mid-operation on reset with no done pulse.

Structure
REQ-033 SHALL place the FSM state enum, mode encodings and the address constants in a shared package lfsr_pkg.
REQ-034 SHALL implement the output buffer as sub-module lfsr_fifo (data plus channel id, level, flush).

Verification
REQ-035 SHALL cover: N=8, CH=1, POLY=0xB8, SEED=0x01, STEP -> single word 0xB8, done pulse, busy low after.
REQ-036 SHALL cover: CH=4, ENMASK=0b1010, RUN, out_ready=1 -> out_ch sequence 1,3,1,3.
REQ-037 SHALL cover: COUNT=20, out_ready=0, DEPTH=8 -> level saturates 8, then release -> exactly 20 words, one done.
REQ-038 SHALL cover: SEED write to channel 0 during RUN same cycle as its turn -> next word from 0 is step of new seed.
REQ-039 SHALL cover: reset asserted mid-COUNT with 5 words buffered -> outputs zero immediately, level 0, no done.
REQ-040 SHALL cover: flush with full FIFO in RUN -> level 0 next cycle, generation resumes the following cycle.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the multi-channel LFSR stream generator:
// FSM states, CTRL mode encodings and the register map.
package lfsr_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_STEP  = 2'b01,
        MODE_RUN   = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_COUNT = 2'd3
    } fsm_e;

    localparam logic [15:0] ADDR_CTRL      = 16'h0010;
    localparam logic [15:0] ADDR_COUNT     = 16'h0011;
    localparam logic [15:0] ADDR_ENMASK    = 16'h0012;
    localparam logic [15:0] ADDR_POLY_BASE = 16'h0020;
    localparam logic [15:0] ADDR_SEED_BASE = 16'h0030;

    function automatic fsm_e mode_to_state(input logic [1:0] m);
        case (mode_e'(m))
            MODE_STEP:  return ST_STEP;
            MODE_RUN:   return ST_RUN;
            MODE_COUNT: return ST_COUNT;
            default:    return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// Register-write port plus the valid/ready output stream and status of lfsr_stream.
interface lfsr_stream_if #(
    parameter int N     = 16,
    parameter int CH    = 4,
    parameter int DEPTH = 8
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int LW  = $clog2(DEPTH) + 1;

    logic           W;
    logic [15:0]    A;
    logic [N-1:0]   D;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;
    logic [CHW-1:0] out_ch;
    logic [LW-1:0]  level;
    logic           busy;
    logic           done;

    modport master (
        output W, A, D, out_ready,
        input  out_valid, out_data, out_ch, level, busy, done
    );

    modport slave (
        input  W, A, D, out_ready,
        output out_valid, out_data, out_ch, level, busy, done
    );
endinterface

// File: rtl/lfsr_fifo.sv
// Output buffer holding {channel, word} entries; single-cycle flush empties it.
module lfsr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic                   valid_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   level_q;
    logic          do_push, do_pop;

    assign valid_o = (level_q != '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && valid_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Empty FIFO presents zeros so the stale RAM word never leaks out.
    assign rdata_o = valid_o ? mem_q[rd_q] : '0;
    assign level_o = level_q;

endmodule

// File: rtl/lfsr_stream.sv
// CH independent Galois LFSRs served round-robin into a buffered output stream,
// controlled by a small register file and an IDLE/RUN/STEP/COUNT sequencer.
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int N     = 16,
    parameter int CH    = 4,
    parameter int DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    lfsr_stream_if.slave  bus
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int LW  = $clog2(DEPTH) + 1;

    fsm_e           fsm_q;
    logic [N-1:0]   count_q;
    logic [CH-1:0]  enmask_q;
    logic [N-1:0]   lfsr_q [CH];
    logic [N-1:0]   poly_q [CH];
    logic [CHW-1:0] rr_q;
    logic           done_q;

    logic           ctrl_wr, count_wr, enmask_wr, flush;
    logic [CH-1:0]  poly_wr, seed_wr, eligible, d_mask;
    logic           sel_found;
    logic [CHW-1:0] sel_ch, idx;
    logic [N-1:0]   lfsr_sel, poly_sel, step_val;
    logic           gen, pop, fifo_full;
    logic [N+CHW-1:0] fifo_rdata;
    logic [LW-1:0]  fifo_level;

    assign ctrl_wr   = bus.W && (bus.A == ADDR_CTRL);
    assign count_wr  = bus.W && (bus.A == ADDR_COUNT);
    assign enmask_wr = bus.W && (bus.A == ADDR_ENMASK);
    assign flush     = ctrl_wr && bus.D[2];

    for (genvar gi = 0; gi < CH; gi++) begin : g_dec
        assign poly_wr[gi] = bus.W && (bus.A == ADDR_POLY_BASE + 16'(gi));
        assign seed_wr[gi] = bus.W && (bus.A == ADDR_SEED_BASE + 16'(gi));
    end

    always_comb begin
        d_mask = '0;
        for (int c = 0; c < CH && c < N; c++) d_mask[c] = bus.D[c];
    end

    // A channel being reprogrammed this cycle sits out; others may still be served.
    assign eligible = enmask_q & ~(poly_wr | seed_wr);

    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        idx       = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            idx = CHW'((int'(rr_q) + k) % CH);
            if (eligible[idx]) begin
                sel_found = 1'b1;
                sel_ch    = idx;
            end
        end
    end

    assign lfsr_sel = lfsr_q[sel_ch];
    assign poly_sel = poly_q[sel_ch];
    assign step_val = lfsr_sel[0] ? ((lfsr_sel >> 1) ^ poly_sel) : (lfsr_sel >> 1);

    assign pop = bus.out_valid && bus.out_ready;
    assign gen = (fsm_q != ST_IDLE)
              && ((fsm_q != ST_COUNT) || (count_q != '0))
              && sel_found
              && (!fifo_full || pop)
              && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                lfsr_q[c] <= '0;
                poly_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (poly_wr[c]) poly_q[c] <= bus.D;
                if (seed_wr[c])
                    lfsr_q[c] <= bus.D;
                else if (gen && (int'(sel_ch) == c))
                    lfsr_q[c] <= step_val;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q    <= ST_IDLE;
            count_q  <= '0;
            enmask_q <= '0;
            rr_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (enmask_wr) enmask_q <= d_mask;
            if (gen) rr_q <= CHW'((int'(sel_ch) + 1) % CH);

            if (count_wr)
                count_q <= bus.D;
            else if (gen && fsm_q == ST_COUNT)
                count_q <= count_q - N'(1);

            case (fsm_q)
                ST_STEP: begin
                    if (gen) begin
                        fsm_q  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (count_q == '0 || (gen && count_q == N'(1))) begin
                        fsm_q  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: fsm_q <= fsm_q;
            endcase

            // A CTRL write always decides the next state, including mode 00 (silent stop).
            if (ctrl_wr) fsm_q <= mode_to_state(bus.D[1:0]);
        end
    end

    lfsr_fifo #(
        .W     (N + CHW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (flush),
        .push_i  (gen),
        .pop_i   (pop),
        .wdata_i ({sel_ch, step_val}),
        .rdata_o (fifo_rdata),
        .valid_o (bus.out_valid),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    assign bus.out_data = fifo_rdata[N-1:0];
    assign bus.out_ch   = fifo_rdata[N +: CHW];
    assign bus.level    = fifo_level;
    assign bus.busy     = (fsm_q != ST_IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed scenarios with random seeds/polynomials; every popped word is checked
// against a channel-level reference model of the LFSR stream.
module tb_lfsr_stream;
    localparam int N = 8, CH = 4, DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_stream_if #(.N(N), .CH(CH), .DEPTH(DEPTH)) bus ();

    lfsr_stream #(.N(N), .CH(CH), .DEPTH(DEPTH)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Monitor: records each accepted word {ch, data} and counts done pulses.
    logic [9:0] obs_q [$];
    int done_cnt = 0;
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            obs_q.push_back({bus.out_ch, bus.out_data});
            $display("[%0t] word ch=%0d data=0x%02h", $time, bus.out_ch, bus.out_data);
        end
        if (!rst && bus.done) done_cnt++;
    end

    // Reference model: per-channel state/poly, enable set, next round-robin start.
    logic [7:0] m_state [4];
    logic [7:0] m_poly  [4];
    logic [3:0] m_en;
    int         m_next;

    function automatic logic [7:0] mstep(input logic [7:0] s, input logic [7:0] p);
        int v;
        v = int'(s);
        if (v % 2 == 1) return 8'((v / 2) ^ int'(p));
        return 8'(v / 2);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_state[c] = 8'h00;
            m_poly[c]  = 8'h00;
        end
        m_en   = 4'b0000;
        m_next = 0;
    endtask

    task automatic model_gen(output logic [1:0] c_o, output logic [7:0] d_o);
        bit found;
        found = 1'b0;
        c_o = 2'd0;
        d_o = 8'h00;
        for (int k = 0; k < 4; k++) begin
            int cc;
            cc = (m_next + k) % 4;
            if (!found && m_en[cc]) begin
                found = 1'b1;
                m_state[cc] = mstep(m_state[cc], m_poly[cc]);
                c_o = 2'(cc);
                d_o = m_state[cc];
                m_next = (cc + 1) % 4;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.W = 1'b1;
        bus.A = a;
        bus.D = d;
        tick();
        bus.W = 1'b0;
        bus.A = 16'h0000;
        bus.D = 8'h00;
    endtask

    task automatic set_poly(input int c, input logic [7:0] v);
        wr(16'h0020 + 16'(c), v);
        m_poly[c] = v;
    endtask

    task automatic set_seed(input int c, input logic [7:0] v);
        wr(16'h0030 + 16'(c), v);
        m_state[c] = v;
    endtask

    task automatic set_en(input logic [3:0] v);
        wr(16'h0012, {4'b0000, v});
        m_en = v;
    endtask

    task automatic randomize_channels();
        for (int c = 0; c < 4; c++) begin
            set_poly(c, 8'($urandom_range(1, 255)) | 8'h80);
            set_seed(c, 8'($urandom_range(1, 255)));
        end
    endtask

    task automatic compare_range(input string tag, input int start, input int n);
        logic [1:0] c;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            model_gen(c, d);
            if (start + i < obs_q.size()) begin
                check({tag, "_ch"},   32'(obs_q[start + i][9:8]), 32'(c));
                check({tag, "_data"}, 32'(obs_q[start + i][7:0]), 32'(d));
            end else begin
                check({tag, "_missing"}, 32'(obs_q.size()), 32'(start + i + 1));
            end
        end
    endtask

    task automatic wait_done(input int dbase, input int budget, input string tag);
        int t;
        t = 0;
        while (done_cnt == dbase && t < budget) begin
            tick();
            t++;
        end
        check(tag, 32'(done_cnt - dbase), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_level"}, 32'(bus.level),     32'd0);
        check({tag, "_busy"},  32'(bus.busy),      32'd0);
        check({tag, "_done"},  32'(bus.done),      32'd0);
        check({tag, "_data"},  32'(bus.out_data),  32'd0);
        check({tag, "_ch"},    32'(bus.out_ch),    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, dbase;
        logic [7:0] newseed;
        int rr_exp [4];
        rr_exp = '{1, 3, 1, 3};

        bus.W = 1'b0;
        bus.A = 16'h0000;
        bus.D = 8'h00;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();
        check_outputs_zero("post_reset");

        // STEP: POLY=0xB8, SEED=0x01 gives one word 0xB8
        set_poly(0, 8'hB8);
        set_seed(0, 8'h01);
        set_en(4'b0001);
        bus.out_ready = 1'b1;
        base  = obs_q.size();
        dbase = done_cnt;
        wr(16'h0010, 8'h01);
        wait_done(dbase, 20, "step_done_seen");
        repeat (3) tick();
        check("step_words", 32'(obs_q.size() - base), 32'd1);
        check("step_literal", 32'((obs_q.size() > base) ? obs_q[base][7:0] : 8'h00), 32'h0000_00B8);
        compare_range("step", base, 1);
        check("step_done_cnt", 32'(done_cnt - dbase), 32'd1);
        check("step_busy_after", 32'(bus.busy), 32'd0);

        // RUN with ENMASK=1010: channels 1,3,1,3,...
        randomize_channels();
        set_en(4'b1010);
        base  = obs_q.size();
        dbase = done_cnt;
        wr(16'h0010, 8'h02);
        repeat (7) tick();
        wr(16'h0010, 8'h00);
        repeat (4) tick();
        check("rr_words", 32'(obs_q.size() - base), 32'd8);
        for (int i = 0; i < 4; i++)
            if (base + i < obs_q.size())
                check("rr_seq", 32'(obs_q[base + i][9:8]), 32'(rr_exp[i]));
        compare_range("rr", base, 8);
        check("rr_stop_no_done", 32'(done_cnt - dbase), 32'd0);
        check("rr_stop_busy", 32'(bus.busy), 32'd0);

        // COUNT=0: immediate done, no words
        base  = obs_q.size();
        dbase = done_cnt;
        wr(16'h0011, 8'd0);
        wr(16'h0010, 8'h03);
        repeat (3) tick();
        check("cnt0_done", 32'(done_cnt - dbase), 32'd1);
        check("cnt0_words", 32'(obs_q.size() - base), 32'd0);
        check("cnt0_busy", 32'(bus.busy), 32'd0);

        // COUNT=20 under backpressure: level saturates, then exactly 20 words
        set_en(4'($urandom_range(1, 15)));
        bus.out_ready = 1'b0;
        wr(16'h0011, 8'd20);
        base  = obs_q.size();
        dbase = done_cnt;
        wr(16'h0010, 8'h03);
        repeat (15) tick();
        check("cnt_level_sat", 32'(bus.level), 32'd8);
        check("cnt_busy_stalled", 32'(bus.busy), 32'd1);
        check("cnt_no_early_done", 32'(done_cnt - dbase), 32'd0);
        bus.out_ready = 1'b1;
        wait_done(dbase, 200, "cnt_done_seen");
        repeat (12) tick();
        check("cnt_words", 32'(obs_q.size() - base), 32'd20);
        compare_range("cnt", base, 20);
        check("cnt_done_once", 32'(done_cnt - dbase), 32'd1);
        check("cnt_busy_after", 32'(bus.busy), 32'd0);
        check("cnt_level_after", 32'(bus.level), 32'd0);

        // SEED write on channel 0's turn: that cycle is skipped, then new chain
        set_en(4'b0001);
        base = obs_q.size();
        wr(16'h0010, 8'h02);
        repeat (5) tick();
        newseed = 8'($urandom_range(1, 255));
        wr(16'h0030, newseed);
        repeat (6) tick();
        wr(16'h0010, 8'h00);
        repeat (4) tick();
        check("seed_words", 32'(obs_q.size() - base), 32'd12);
        compare_range("seed_old", base, 5);
        m_state[0] = newseed;
        compare_range("seed_new", base + 5, 7);

        // Reset in the middle of COUNT with 5 words buffered
        bus.out_ready = 1'b0;
        wr(16'h0011, 8'd20);
        dbase = done_cnt;
        wr(16'h0010, 8'h03);
        repeat (5) tick();
        check("rst_pre_level", 32'(bus.level), 32'd5);
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (3) tick();
        check_outputs_zero("rst_after");
        check("rst_no_done", 32'(done_cnt - dbase), 32'd0);

        // Flush with a full FIFO in RUN
        randomize_channels();
        set_en(4'b1111);
        bus.out_ready = 1'b0;
        wr(16'h0010, 8'h02);
        repeat (10) tick();
        check("flush_pre_level", 32'(bus.level), 32'd8);
        begin
            logic [1:0] dc;
            logic [7:0] dd;
            for (int i = 0; i < 8; i++) model_gen(dc, dd);
        end
        base = obs_q.size();
        wr(16'h0010, 8'h06);
        check("flush_level", 32'(bus.level), 32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("flush_resume_level", 32'(bus.level), 32'd1);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        wr(16'h0010, 8'h00);
        repeat (4) tick();
        check("flush_words", 32'(obs_q.size() - base), 32'd7);
        compare_range("flush", base, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
